sobel_frame_ctrl: RTL
=====================

Name: sobel_frame_ctrl

Overview:
Frame-level sequencer for the 3x3 Sobel edge-detector datapath. It accepts a raster-order 8-bit grayscale pixel stream and keeps two line buffers plus a 3x3 tap register. It presents each interior 3x3 window, with a latched threshold, to the edge-detector instance, which has 1-cycle registered output. It then tags the returned edge bit with its pixel address and signals frame completion.

Parameters:
IMG_W, 32, image width in pixels (>=3)
IMG_H, 32, image height in pixels (>=3)
AW, $clog2(IMG_W*IMG_H), result address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse: begin frame
t_in  in  8  edge threshold, sampled on accepted start
pix_valid  in  1  pixel stream valid
pix_data  in  8  pixel value, raster order (row-major, col 0 first)
pix_ready  out  1  controller can accept pixel
win  out  72  3x3 window to detector; tap k=(dr+1)*3+(dc+1) at bits [8k+7:8k], dr/dc in {-1,0,+1} relative to center
thr_out  out  8  latched threshold to detector t input
win_valid  out  1  win holds a new interior window this cycle
ed_in  in  1  detector out (registered one clk after win)
res_valid  out  1  res_bit/res_addr valid
res_bit  out  1  edge decision for res_addr
res_addr  out  AW  center address = row*IMG_W+col
busy  out  1  frame in progress
done  out  1  one-cycle pulse after last result

Behaviour:
- Single clock clk; reset rst_n asynchronous, active-low. All outputs and state are 0 during reset, including pix_ready, win, thr_out, counters and line buffers' read registers; FSM enters IDLE. Deasserting rst_n mid-frame aborts the frame: no further results and no done.
- FSM states: IDLE, FILL, RUN, DRAIN, FINISH.
- IDLE: pix_ready=0, busy=0. start=1 → latch t_in into thr_out, clear row/col counters → FILL.
- FILL: rows 0-1 plus first two pixels of row 2. pix_ready=1. Transfer occurs on pix_valid&pix_ready.
- FILL→RUN when a transfer fills position (2,1).
- RUN: pix_ready=1. Each transfer at (r,c) shifts the column into the tap register, updates line buffers at col c, and advances col (wrap at IMG_W-1 → col 0, row+1).
- Window output: a transfer at (r,c) with r>=2, c>=2 registers win centered at (r-1,c-1) and pulses win_valid one cycle later. Transfers with c<2 update buffers/taps only, with win_valid=0.
- RUN→DRAIN on transfer of (IMG_H-1, IMG_W-1). pix_ready=0 in DRAIN.
- DRAIN: wait for final result (2 cycles) → FINISH.
- FINISH: done=1 for one cycle, busy=0 → IDLE.
- busy=1 in FILL/RUN/DRAIN/FINISH-until-done.
- Result path: res_valid = win_valid delayed 1 clk; res_addr = window center address delayed 1 clk; res_bit = ed_in sampled on the same cycle.
- Latency: pixel transfer to res_valid is exactly 2 clk.
- Exactly (IMG_W-2)*(IMG_H-2) results per frame, in raster order. Border pixels produce no result.
- Backpressure: pix_valid gaps stall the pipeline; no state advances without a transfer. Result stream content is independent of gaps.
- start while busy=1 is ignored; thr_out is unchanged. start coincident with done is ignored.
- Line buffers: two IMG_W x 8 arrays indexed by col. Rows older than r-2 are overwritten in place.
- thr_out holds its value between frames.

Optional Feature:
EDGE_CNT_EN: when defined, adds output edge_cnt [AW-1:0].
- edge_cnt clears on accepted start and increments on each res_valid with res_bit=1.
- edge_cnt is stable from the done pulse until the next accepted start; reset value 0.
- When EDGE_CNT_EN is undefined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- IMG_W=IMG_H=4, t_in=50, all pixels 50, pix_valid held 1 → 4 results, addrs 5,6,9,10, res_bit=0 each; done 3 clk after last pixel transfer; busy falls with done.
- IMG_W=IMG_H=4, t_in=50, cols 0-1=0, cols 2-3=20 → addrs 5,6,9,10 all res_bit=1 (|gx|=80>50); edge_cnt=4 if EDGE_CNT_EN.
- Same image with t_in=80 → all res_bit=0 (80 not >80); thr_out=80 after start.
- Vertical-step image with pix_valid random 50% duty → identical res_addr/res_bit sequence as the unstalled run; each res_valid exactly 2 clk after its triggering transfer.
- start pulsed again mid-frame with t_in=200 → ignored; thr_out keeps 50; still exactly 4 results.
- rst_n low after 7 pixels → all outputs 0 immediately (async); next start runs a clean full frame with correct results.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for a 3x3 Sobel detector: buffers raster pixels, emits interior windows, tags results.
// Optional feature: define EDGE_CNT_EN to add the edge_cnt output (count of edge results in the last frame).
module sobel_frame_ctrl #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    t_in,
  input  logic          pix_valid,
  input  logic [7:0]    pix_data,
  output logic          pix_ready,
  output logic [71:0]   win,
  output logic [7:0]    thr_out,
  output logic          win_valid,
  input  logic          ed_in,
  output logic          res_valid,
  output logic          res_bit,
  output logic [AW-1:0] res_addr,
  output logic          busy,
`ifdef EDGE_CNT_EN
  output logic          done,
  output logic [AW-1:0] edge_cnt
`else
  output logic          done
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [AW-1:0]  pix_addr;
  logic [AW-1:0]  win_addr;
  logic           drain_cnt;
  logic [7:0]     lb0 [IMG_W];
  logic [7:0]     lb1 [IMG_W];
  logic [7:0]     lb0_rd;
  logic [7:0]     lb1_rd;
  logic [71:0]    taps;
  logic [71:0]    taps_nxt;
  logic           xfer;
  logic           start_ok;
  logic           last_col;
  logic           last_row;
  logic           win_ok;

  // Pixel handshake: a pixel moves only on a cycle where pix_valid and pix_ready are
  // both high at the rising edge; pix_valid may be dropped at any time, stalling all state.
  assign xfer     = pix_valid & pix_ready;
  assign start_ok = (state == IDLE) & start;
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  assign win_ok   = (row >= RW'(2)) & (col >= CW'(2));
  assign lb0_rd   = lb0[col];
  assign lb1_rd   = lb1[col];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (xfer && (row == RW'(2)) && (col == CW'(1))) state_nxt = RUN;
      end
      RUN: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (xfer && last_col && last_row) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Two DRAIN cycles cover the window register and the detector's output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= 1'b0;
    end else if (state == DRAIN) begin
      drain_cnt <= ~drain_cnt;
    end else begin
      drain_cnt <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row      <= '0;
      col      <= '0;
      pix_addr <= '0;
      thr_out  <= '0;
    end else if (start_ok) begin
      row      <= '0;
      col      <= '0;
      pix_addr <= '0;
      thr_out  <= t_in;
    end else if (xfer) begin
      pix_addr <= pix_addr + AW'(1);
      if (last_col) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // lb0 holds row r-2, lb1 row r-1; each transfer ages column col by one row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
    end else if (xfer) begin
      lb0[col] <= lb1_rd;
      lb1[col] <= pix_data;
    end
  end

  // Tap k=(dr+1)*3+(dc+1); the incoming column lands at dc=+1, older columns shift left.
  always_comb begin
    taps_nxt          = taps;
    taps_nxt[0*8 +: 8] = taps[1*8 +: 8];
    taps_nxt[1*8 +: 8] = taps[2*8 +: 8];
    taps_nxt[2*8 +: 8] = lb0_rd;
    taps_nxt[3*8 +: 8] = taps[4*8 +: 8];
    taps_nxt[4*8 +: 8] = taps[5*8 +: 8];
    taps_nxt[5*8 +: 8] = lb1_rd;
    taps_nxt[6*8 +: 8] = taps[7*8 +: 8];
    taps_nxt[7*8 +: 8] = taps[8*8 +: 8];
    taps_nxt[8*8 +: 8] = pix_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps      <= '0;
      win       <= '0;
      win_valid <= 1'b0;
      win_addr  <= '0;
    end else begin
      win_valid <= xfer & win_ok;
      if (xfer) begin
        taps <= taps_nxt;
        if (win_ok) begin
          win      <= taps_nxt;
          win_addr <= pix_addr - AW'(IMG_W) - AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_addr  <= '0;
    end else begin
      res_valid <= win_valid;
      res_addr  <= win_addr;
    end
  end

  // The detector output is already registered, so it aligns with res_valid untouched.
  assign res_bit = res_valid & ed_in;

`ifdef EDGE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (start_ok) begin
      edge_cnt <= '0;
    end else if (res_valid && res_bit) begin
      edge_cnt <= edge_cnt + AW'(1);
    end
  end
`endif

endmodule
